// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction fetch
// (IF) and the MEM stage (DM). Serialises accesses, holds each access on the
// memory for MEM_LAT cycles, and reports completion and stalls to the pipeline.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking between
// IF and DM. Default (undefined) is fixed DM priority.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   if_req/if_addr                  fetch read request and address
//   if_done/if_rdata/if_stall       fetch completion pulse, fetched word, stall
//   dm_req/dm_we/dm_addr/dm_wdata   data load/store request
//   dm_done/dm_rdata/dm_stall       data completion pulse, load data, stall
//   mem_addr/mem_rd_wr/mem_op_en/mem_wr_data/mem_rd_data   memory macro port
//   busy                            arbiter is not idle
module mem_arbiter #(
  parameter int unsigned WD_SIZE = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int          MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_done,
  output logic [WD_SIZE-1:0] if_rdata,
  output logic               if_stall,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [WD_SIZE-1:0] dm_wdata,
  output logic               dm_done,
  output logic [WD_SIZE-1:0] dm_rdata,
  output logic               dm_stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_wr,
  output logic               mem_op_en,
  output logic [WD_SIZE-1:0] mem_wr_data,
  input  logic [WD_SIZE-1:0] mem_rd_data,
  output logic               busy
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  generate
    if (MEM_LAT < 1) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  logic [1:0]         state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               gnt_dm, gnt_dm_nx;
  logic               last_dm, last_dm_nx;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic               we_q, we_nx;
  logic [WD_SIZE-1:0] wdata_q, wdata_nx;
  logic [WD_SIZE-1:0] if_rdata_nx, dm_rdata_nx;
  logic               pick_dm;

  // Port selection when leaving IDLE; only meaningful when a request is pending.
`ifdef MEM_ARB_RR_EN
  assign pick_dm = dm_req & (~if_req | ~last_dm);
`else
  assign pick_dm = dm_req;
`endif

  // Stalls follow the live request so the stage freezes in the request cycle.
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Next-state and datapath-latch logic.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    gnt_dm_nx   = gnt_dm;
    last_dm_nx  = last_dm;
    addr_nx     = addr_q;
    we_nx       = we_q;
    wdata_nx    = wdata_q;
    if_rdata_nx = if_rdata;
    dm_rdata_nx = dm_rdata;
    case (state)
      IDLE: begin
        if (if_req | dm_req) begin
          gnt_dm_nx = pick_dm;
          addr_nx   = pick_dm ? dm_addr : if_addr;
          we_nx     = pick_dm & dm_we;
          wdata_nx  = pick_dm ? dm_wdata : '0;
          cnt_nx    = CNT_W'(MEM_LAT - 1);
          state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          // Only the last access cycle's read data is kept.
          if (gnt_dm) begin
            if (!we_q) dm_rdata_nx = mem_rd_data;
          end else begin
            if_rdata_nx = mem_rd_data;
          end
          state_nx = DONE;
        end
      end
      DONE: begin
        last_dm_nx = gnt_dm;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latches and registered outputs; outputs are decoded from next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_dm      <= 1'b0;
      last_dm     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      mem_addr    <= '0;
      mem_rd_wr   <= 1'b0;
      mem_op_en   <= 1'b0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      gnt_dm      <= gnt_dm_nx;
      last_dm     <= last_dm_nx;
      addr_q      <= addr_nx;
      we_q        <= we_nx;
      wdata_q     <= wdata_nx;
      if_rdata    <= if_rdata_nx;
      dm_rdata    <= dm_rdata_nx;
      if_done     <= (state_nx == DONE) & ~gnt_dm_nx;
      dm_done     <= (state_nx == DONE) & gnt_dm_nx;
      mem_op_en   <= (state_nx == ACCESS);
      mem_addr    <= (state_nx == ACCESS) ? addr_nx : '0;
      mem_rd_wr   <= (state_nx == ACCESS) & we_nx;
      mem_wr_data <= (state_nx == ACCESS) ? wdata_nx : '0;
      busy        <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-timing model plus directed scenarios.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rd_data;
  logic        if_done, if_stall, dm_done, dm_stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wr_data;
  logic        mem_rd_wr, mem_op_en, busy;

  mem_arbiter #(.WD_SIZE(32), .ADDR_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr), .mem_op_en(mem_op_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a granted transaction occupies the memory for MEM_LAT cycles, then
  // one completion cycle, then one idle cycle before the next grant.
  bit          model_ok = 0;
  bit          m_active, m_gnt_dm, m_last_dm, m_we;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  always @(posedge clk) begin
    if (!reset_n) begin
      model_ok = 1; m_active = 0; m_age = 0; m_gnt_dm = 0; m_last_dm = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
    end else if (m_active) begin
      if (m_age == MEM_LAT - 1) begin
        if (m_gnt_dm) begin
          if (!m_we) m_dm_rdata = mem_rd_data;
        end else m_if_rdata = mem_rd_data;
      end
      if (m_age == MEM_LAT) begin
        m_active = 0; m_last_dm = m_gnt_dm;
      end else m_age++;
    end else if (if_req || dm_req) begin
`ifdef MEM_ARB_RR_EN
      m_gnt_dm = dm_req && (!if_req || !m_last_dm);
`else
      m_gnt_dm = dm_req;
`endif
      m_addr   = m_gnt_dm ? dm_addr : if_addr;
      m_we     = m_gnt_dm ? dm_we : 1'b0;
      m_wdata  = (m_gnt_dm && dm_we) ? dm_wdata : (m_gnt_dm ? dm_wdata : 32'h0);
      m_active = 1; m_age = 0;
    end
  end

  // Monitor counters used by directed checks.
  int          op_cnt, wr_cnt, if_stall_cnt, if_done_cnt, dm_done_cnt;
  logic [31:0] last_op_addr, last_wdata;
  bit          order[$];
  bit          e_op, e_if_done, e_dm_done;

  task automatic clr_mon();
    op_cnt = 0; wr_cnt = 0; if_stall_cnt = 0; if_done_cnt = 0; dm_done_cnt = 0;
    last_op_addr = 0; last_wdata = 0; order.delete();
  endtask

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      e_op      = m_active && (m_age < MEM_LAT);
      e_if_done = m_active && (m_age == MEM_LAT) && !m_gnt_dm;
      e_dm_done = m_active && (m_age == MEM_LAT) && m_gnt_dm;
      chk("mem_op_en",   32'(mem_op_en),   32'(e_op));
      chk("mem_addr",    mem_addr,         e_op ? m_addr : 32'h0);
      chk("mem_rd_wr",   32'(mem_rd_wr),   32'(e_op && m_we));
      chk("mem_wr_data", mem_wr_data,      e_op ? m_wdata : 32'h0);
      chk("if_done",     32'(if_done),     32'(e_if_done));
      chk("dm_done",     32'(dm_done),     32'(e_dm_done));
      chk("if_rdata",    if_rdata,         m_if_rdata);
      chk("dm_rdata",    dm_rdata,         m_dm_rdata);
      chk("busy",        32'(busy),        32'(m_active));
      chk("if_stall",    32'(if_stall),    32'(if_req && !e_if_done));
      chk("dm_stall",    32'(dm_stall),    32'(dm_req && !e_dm_done));
      chk("done_excl",   32'(if_done & dm_done), 32'h0);
      if (mem_op_en) begin
        op_cnt++; last_op_addr = mem_addr;
        if (mem_rd_wr) begin wr_cnt++; last_wdata = mem_wr_data; end
      end
      if (if_stall) if_stall_cnt++;
      if (if_done) begin if_done_cnt++; order.push_back(1'b0); end
      if (dm_done) begin dm_done_cnt++; order.push_back(1'b1); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts negedges until the selected done is seen; bounded.
  task automatic wait_done(input bit dm, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      seen = dm ? dm_done : if_done;
    end
    if (!seen) chk(dm ? "dm_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  logic [3:0] ord_got;
  logic [3:0] ord_exp;

  initial begin
    reset_n = 0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rd_data = 0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_en", 32'(mem_op_en), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    tick(); reset_n = 1;

    // Fetch only.
    clr_mon(); if_addr = 32'h40; mem_rd_data = 32'h00500093; if_req = 1;
    wait_done(0, lat);
    tick(); if_req = 0;
    chk("fetch_lat", 32'(lat), 32'd4);
    chk("fetch_op_cycles", 32'(op_cnt), 32'd2);
    chk("fetch_addr", last_op_addr, 32'h40);
    chk("fetch_stall_cycles", 32'(if_stall_cnt), 32'd3);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    chk("fetch_done_pulses", 32'(if_done_cnt), 32'd1);

    // Load with read data changing between access cycles.
    clr_mon(); dm_addr = 32'h104; dm_we = 0; mem_rd_data = 32'h0; dm_req = 1;
    tick(); mem_rd_data = 32'hAAAA5555;
    tick(); mem_rd_data = 32'h12345678;
    wait_done(1, lat);
    tick(); dm_req = 0;
    chk("load_lat_rest", 32'(lat), 32'd2);
    chk("load_addr", last_op_addr, 32'h104);
    chk("load_rdata", dm_rdata, 32'h12345678);

    // Store leaves load data untouched.
    clr_mon(); dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_we = 1;
    mem_rd_data = 32'hFFFF0000; dm_req = 1;
    wait_done(1, lat);
    tick(); dm_req = 0; dm_we = 0;
    chk("store_lat", 32'(lat), 32'd4);
    chk("store_wr_cycles", 32'(wr_cnt), 32'd2);
    chk("store_wdata", last_wdata, 32'hDEADBEEF);
    chk("store_rdata_kept", dm_rdata, 32'h12345678);
    chk("store_done_pulses", 32'(dm_done_cnt), 32'd1);

    // Fetch request dropped after grant still completes.
    clr_mon(); if_addr = 32'h80; mem_rd_data = 32'h0BADF00D; if_req = 1;
    tick(); if_req = 0;
    wait_done(0, lat);
    tick();
    chk("drop_lat_rest", 32'(lat), 32'd3);
    chk("drop_done_pulses", 32'(if_done_cnt), 32'd1);

    // Fresh reset, then simultaneous requests: DM first, IF four cycles later.
    reset_n = 0; tick(); reset_n = 1;
    clr_mon(); if_addr = 32'h44; dm_addr = 32'h108; dm_we = 0;
    mem_rd_data = 32'hCAFEF00D; if_req = 1; dm_req = 1;
    wait_done(1, lat);
    chk("tie_dm_lat", 32'(lat), 32'd4);
    chk("tie_if_not_first", 32'(if_done_cnt), 32'd0);
    tick(); dm_req = 0;
    wait_done(0, lat);
    tick(); if_req = 0;
    chk("tie_if_gap", 32'(lat), 32'd4);
    chk("tie_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("tie_dm_rdata", dm_rdata, 32'hCAFEF00D);

    // Both held for four grants.
    clr_mon(); if_addr = 32'h48; dm_addr = 32'h10C; mem_rd_data = 32'h13572468;
    if_req = 1; dm_req = 1;
    for (int i = 0; i < 40 && order.size() < 4; i++) @(negedge clk);
    tick(); if_req = 0; dm_req = 0;
    chk("held_grants", 32'(order.size() >= 4), 32'd1);
    ord_got = 4'b0;
    for (int i = 0; i < 4 && i < order.size(); i++) ord_got[i] = order[i];
`ifdef MEM_ARB_RR_EN
    ord_exp = 4'b0101;
`else
    ord_exp = 4'b1111;
`endif
    chk("held_order", 32'(ord_got), 32'(ord_exp));
    repeat (8) tick();

    // Reset in the middle of a load.
    clr_mon(); dm_addr = 32'h200; dm_we = 0; mem_rd_data = 32'h55AA55AA; dm_req = 1;
    tick();
    reset_n = 0;
    tick(); reset_n = 1; dm_req = 0;
    @(negedge clk);
    chk("rstmid_op_en", 32'(mem_op_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_dm_rdata", dm_rdata, 32'd0);
    repeat (6) @(negedge clk);
    chk("rstmid_no_done", 32'(dm_done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
